mor1kx_wb_arbiter_marocchino: RTL and testbench
===============================================

// Module: mor1kx_wb_arbiter_marocchino
//
// PURPOSE
//   Arbitrates the single MAROCCHINO register-file write-back port among NUM_REQ
//   result producers (LSU, MUL, DIV, FPU-32, ...).
//   Each producer holds a completed result until it is acknowledged.
//   The arbiter grants one producer per write-back advance and registers the
//   winner's result, destination address and write flag into the WB stage.
//   Sits between the execution units and the WB mux / register file.
//
// PARAMETERS
//   NUM_REQ               4   number of requesters (2..8)
//   OPTION_OPERAND_WIDTH  32  result width
//   OPTION_RF_ADDR_WIDTH  5   destination register address width
//
// PORTS
//   clk               in   1        clock
//   rst               in   1        reset, synchronous, active-high
//   padv_wb_i         in   1        write-back stage advance
//   pipeline_flush_i  in   1        pipeline flush
//   req_i             in   NUM_REQ  per-requester result valid
//   req_rf_wb_i       in   NUM_REQ  per-requester RF write request
//   req_result_i      in   NUM_REQ*OPTION_OPERAND_WIDTH  results, requester k at [k*W +: W]
//   req_rfd_adr_i     in   NUM_REQ*OPTION_RF_ADDR_WIDTH  destination addresses, packed like req_result_i
//   ack_o             out  NUM_REQ  one-hot grant acknowledge (combinational)
//   wb_valid_o        out  1        WB stage holds a granted result
//   wb_rf_wb_o        out  1        RF write enable for the WB stage
//   wb_result_o       out  OPTION_OPERAND_WIDTH  registered result
//   wb_rfd_adr_o      out  OPTION_RF_ADDR_WIDTH  registered destination address
//   wb_grant_o        out  NUM_REQ  registered one-hot index of the WB owner
//   wb_pending_o      out  1        some req_i high but no ack this cycle
//
// BEHAVIOUR
//   - Reset values:
//     - wb_valid_o, wb_rf_wb_o, wb_result_o, wb_rfd_adr_o, wb_grant_o all 0.
//     - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
//   - Grant:
//     - Evaluated only when padv_wb_i=1 and pipeline_flush_i=0.
//     - Search starts at index (last+1) mod NUM_REQ and wraps upward.
//     - The first index with req_i=1 wins; ack_o is its one-hot, in the same cycle.
//     - ack_o is 0 in every other case.
//   - Requester handshake:
//     - Hold req_i, req_rf_wb_i, result and address stable until ack_o[k] is seen.
//     - Drop req_i the next cycle unless a new result is ready.
//     - Zero-latency ack: data is captured at the clock edge ending the ack cycle.
//   - Edge with a grant:
//     - wb_valid_o <= 1 and wb_rf_wb_o <= req_rf_wb_i[k].
//     - Load wb_result_o, wb_rfd_adr_o and wb_grant_o from requester k.
//     - last <= k.
//   - Edge with padv_wb_i=1 and no request:
//     - wb_valid_o <= 0, wb_rf_wb_o <= 0, wb_grant_o <= 0.
//     - Data registers hold; last unchanged.
//   - padv_wb_i=0: all registers hold; requests wait (no timeout).
//   - pipeline_flush_i=1 (priority over padv_wb_i):
//     - ack_o = 0; wb_valid_o, wb_rf_wb_o, wb_grant_o <= 0.
//     - last unchanged; data registers hold.
//     - Requesters discard their own pending results on flush.
//   - Simultaneous requests: exactly one ack per advance, never more.
//     - With all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.
//   - Wrap: with last=NUM_REQ-1 the search begins at 0.
//   - wb_pending_o = |req_i & ~|ack_o (stall hint for the control unit).
//   - Reset mid-operation: ack_o low during reset; all state returns to reset values.
//
// CONFIGURATION
//   MOR1KX_WB_ARB_LSU_PRIO_EN
//   - Defined: requester 0 (LSU) has absolute priority.
//     - Whenever req_i[0]=1 it is granted, regardless of last.
//     - Round-robin applies only among requesters 1..NUM_REQ-1.
//     - last is updated only on grants to 1..NUM_REQ-1.
//   - Undefined: pure round-robin over all NUM_REQ requesters.
//
// TESTING
//   1. Reset, single request:
//      - Stimulus: req_i=0001, result 0xDEADBEEF, address 5, rf_wb=1, padv=1.
//      - Response: ack_o=0001; next cycle wb_valid=1, wb_rf_wb=1,
//        wb_result=0xDEADBEEF, wb_rfd_adr=5, wb_grant=0001.
//   2. All four requests held for 4 advances (macro off):
//      - Response: acks 0001, 0010, 0100, 1000 in order.
//      - wb_result tracks each requester's data in turn.
//   3. Flush with req_i=0110 and padv=1:
//      - Response: ack_o=0 and wb_valid=0 next cycle.
//      - Next advance without flush grants 1 if last was 0.
//   4. padv_wb_i=0 for 3 cycles with req_i=0100:
//      - Response: ack_o=0 and wb_pending_o=1 each cycle; outputs hold.
//      - Grant 0100 occurs on the first padv.
//   5. req_rf_wb_i=0 for the granted requester:
//      - Response: wb_valid=1 and wb_rf_wb=0.
//   6. Macro on, req_i=1011 held for 3 advances:
//      - Response: ack 0001 three times; requesters 1 and 3 starve until req_i[0] drops.
//      - Then ack 0010, then 1000.

Source files
------------

// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// mor1kx_wb_arbiter_marocchino
//   Arbitrates the single MAROCCHINO register-file write-back port among
//   NUM_REQ result producers (LSU, MUL, DIV, FPU-32, ...). One producer is
//   acknowledged per write-back advance. Its result, destination address and
//   write flag are registered into the WB stage.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   padv_wb_i         write-back stage advance
//   pipeline_flush_i  pipeline flush (overrides padv_wb_i)
//   req_i             per-requester result valid
//   req_rf_wb_i       per-requester RF write request
//   req_result_i      packed results, requester k at [k*W +: W]
//   req_rfd_adr_i     packed destination addresses, same packing
//   ack_o             combinational one-hot grant
//   wb_valid_o        WB stage holds a granted result
//   wb_rf_wb_o        RF write enable for the WB stage
//   wb_result_o       registered result
//   wb_rfd_adr_o      registered destination address
//   wb_grant_o        registered one-hot owner of the WB stage
//   wb_pending_o      some request is waiting without an ack this cycle
//
// Configuration
//   MOR1KX_WB_ARB_LSU_PRIO_EN  requester 0 (LSU) gets absolute priority.
//                              Round-robin then covers only 1..NUM_REQ-1.

module mor1kx_wb_arbiter_marocchino #(
  parameter int NUM_REQ              = 4,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    padv_wb_i,
  input  logic                                    pipeline_flush_i,
  input  logic [NUM_REQ-1:0]                      req_i,
  input  logic [NUM_REQ-1:0]                      req_rf_wb_i,
  input  logic [NUM_REQ*OPTION_OPERAND_WIDTH-1:0] req_result_i,
  input  logic [NUM_REQ*OPTION_RF_ADDR_WIDTH-1:0] req_rfd_adr_i,
  output logic [NUM_REQ-1:0]                      ack_o,
  output logic                                    wb_valid_o,
  output logic                                    wb_rf_wb_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]         wb_result_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]         wb_rfd_adr_o,
  output logic [NUM_REQ-1:0]                      wb_grant_o,
  output logic                                    wb_pending_o
);

  localparam int unsigned N    = NUM_REQ;
  localparam int unsigned IDXW = $clog2(NUM_REQ);

  logic [IDXW-1:0]                 r_last;
  logic                            r_valid;
  logic                            r_rf_wb;
  logic [OPTION_OPERAND_WIDTH-1:0] r_result;
  logic [OPTION_RF_ADDR_WIDTH-1:0] r_rfd_adr;
  logic [NUM_REQ-1:0]              r_grant;

  logic [NUM_REQ-1:0]              w_ack;
  logic [IDXW-1:0]                 w_sel;
  logic                            w_found;
  int unsigned                     w_idx;

  // Rotating search starting one past the last winner.
  always_comb begin
    w_ack   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    if (!rst && padv_wb_i && !pipeline_flush_i) begin
`ifdef MOR1KX_WB_ARB_LSU_PRIO_EN
      if (req_i[0]) begin
        w_found = 1'b1;
        w_sel   = '0;
      end else begin
        // r_last stays within 1..N-1 here, so the ring is 1..N-1.
        for (int unsigned i = 1; i < N; i++) begin
          w_idx = 1 + ((32'(r_last) - 1 + i) % (N - 1));
          if (!w_found && req_i[w_idx]) begin
            w_found = 1'b1;
            w_sel   = IDXW'(w_idx);
          end
        end
      end
`else
      for (int unsigned i = 1; i <= N; i++) begin
        w_idx = (32'(r_last) + i) % N;
        if (!w_found && req_i[w_idx]) begin
          w_found = 1'b1;
          w_sel   = IDXW'(w_idx);
        end
      end
`endif
      if (w_found) w_ack[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= IDXW'(N - 1);
      r_valid   <= 1'b0;
      r_rf_wb   <= 1'b0;
      r_result  <= '0;
      r_rfd_adr <= '0;
      r_grant   <= '0;
    end else if (pipeline_flush_i) begin
      r_valid <= 1'b0;
      r_rf_wb <= 1'b0;
      r_grant <= '0;
    end else if (padv_wb_i) begin
      if (w_found) begin
        r_valid   <= 1'b1;
        r_rf_wb   <= req_rf_wb_i[w_sel];
        r_result  <= req_result_i[w_sel*OPTION_OPERAND_WIDTH +: OPTION_OPERAND_WIDTH];
        r_rfd_adr <= req_rfd_adr_i[w_sel*OPTION_RF_ADDR_WIDTH +: OPTION_RF_ADDR_WIDTH];
        r_grant   <= w_ack;
`ifdef MOR1KX_WB_ARB_LSU_PRIO_EN
        if (w_sel != '0) r_last <= w_sel;
`else
        r_last <= w_sel;
`endif
      end else begin
        r_valid <= 1'b0;
        r_rf_wb <= 1'b0;
        r_grant <= '0;
      end
    end
  end

  assign ack_o        = w_ack;
  assign wb_valid_o   = r_valid;
  assign wb_rf_wb_o   = r_rf_wb;
  assign wb_result_o  = r_result;
  assign wb_rfd_adr_o = r_rfd_adr;
  assign wb_grant_o   = r_grant;
  assign wb_pending_o = (|req_i) & ~(|w_ack);

endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// Directed testbench for mor1kx_wb_arbiter_marocchino (NUM_REQ=4, W=32, A=5).
`timescale 1ns/1ps

module tb_mor1kx_wb_arbiter_marocchino;

  logic         clk = 1'b0;
  logic         rst;
  logic         padv_wb_i;
  logic         pipeline_flush_i;
  logic [3:0]   req_i;
  logic [3:0]   req_rf_wb_i;
  logic [127:0] req_result_i;
  logic [19:0]  req_rfd_adr_i;
  logic [3:0]   ack_o;
  logic         wb_valid_o;
  logic         wb_rf_wb_o;
  logic [31:0]  wb_result_o;
  logic [4:0]   wb_rfd_adr_o;
  logic [3:0]   wb_grant_o;
  logic         wb_pending_o;

  int n_tests = 0;
  int n_fail  = 0;

  mor1kx_wb_arbiter_marocchino #(
    .NUM_REQ(4),
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .padv_wb_i(padv_wb_i),
    .pipeline_flush_i(pipeline_flush_i),
    .req_i(req_i),
    .req_rf_wb_i(req_rf_wb_i),
    .req_result_i(req_result_i),
    .req_rfd_adr_i(req_rfd_adr_i),
    .ack_o(ack_o),
    .wb_valid_o(wb_valid_o),
    .wb_rf_wb_o(wb_rf_wb_o),
    .wb_result_o(wb_result_o),
    .wb_rfd_adr_o(wb_rfd_adr_o),
    .wb_grant_o(wb_grant_o),
    .wb_pending_o(wb_pending_o)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [31:0] res,
                          input logic [4:0] adr, input logic rfwb);
    req_result_i[k*32 +: 32] = res;
    req_rfd_adr_i[k*5 +: 5]  = adr;
    req_rf_wb_i[k]           = rfwb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; padv_wb_i = 1'b1; pipeline_flush_i = 1'b0;
    req_i = 4'b1111; req_rf_wb_i = '1;
    req_result_i = '1; req_rfd_adr_i = '1;
    tick();
    #1;
    n_tests++;
    if (ack_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack_o); end
    n_tests++;
    if ({wb_valid_o, wb_rf_wb_o, wb_grant_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got valid=%b rfwb=%b grant=%b expected 0", wb_valid_o, wb_rf_wb_o, wb_grant_o);
    end
    n_tests++;
    if (wb_result_o !== 32'h0 || wb_rfd_adr_o !== 5'd0) begin
      n_fail++; $display("FAIL reset_data: got result=%h adr=%0d expected 0", wb_result_o, wb_rfd_adr_o);
    end
    tick();
    rst = 1'b0; req_i = '0; req_rf_wb_i = '0; req_result_i = '0; req_rfd_adr_i = '0;
  endtask

  task automatic test_single();
    set_data(0, 32'hDEADBEEF, 5'd5, 1'b1);
    req_i = 4'b0001; padv_wb_i = 1'b1;
    #1;
    n_tests++;
    if (ack_o !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", ack_o); end
    n_tests++;
    if (wb_pending_o !== 1'b0) begin n_fail++; $display("FAIL single_pending: got %b expected 0", wb_pending_o); end
    tick();
    req_i = 4'b0000;
    n_tests++;
    if ({wb_valid_o, wb_rf_wb_o, wb_grant_o} !== 6'b11_0001 || wb_result_o !== 32'hDEADBEEF || wb_rfd_adr_o !== 5'd5) begin
      n_fail++; $display("FAIL single_wb: got valid=%b rfwb=%b grant=%b result=%h adr=%0d expected 1 1 0001 deadbeef 5",
                         wb_valid_o, wb_rf_wb_o, wb_grant_o, wb_result_o, wb_rfd_adr_o);
    end
    // Advance with nothing requested: flags clear, data holds.
    tick();
    n_tests++;
    if ({wb_valid_o, wb_rf_wb_o, wb_grant_o} !== 6'b0 || wb_result_o !== 32'hDEADBEEF || wb_rfd_adr_o !== 5'd5) begin
      n_fail++; $display("FAIL idle_adv: got valid=%b rfwb=%b grant=%b result=%h adr=%0d expected 0 0 0000 deadbeef 5",
                         wb_valid_o, wb_rf_wb_o, wb_grant_o, wb_result_o, wb_rfd_adr_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, 32'h1000_0000 + k, 5'(10 + k), 1'b1);
    req_i = 4'b1111; padv_wb_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      #1;
      n_tests++;
      if (ack_o !== exp) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, ack_o, exp); end
      tick();
      n_tests++;
      if (wb_grant_o !== exp || wb_valid_o !== 1'b1 || wb_result_o !== 32'h1000_0000 + (i % 4) || wb_rfd_adr_o !== 5'(10 + (i % 4))) begin
        n_fail++; $display("FAIL rr_wb[%0d]: got grant=%b valid=%b result=%h adr=%0d expected %b 1 %h %0d",
                           i, wb_grant_o, wb_valid_o, wb_result_o, wb_rfd_adr_o, exp, 32'h1000_0000 + (i % 4), 10 + (i % 4));
      end
    end
    req_i = 4'b0000;
  endtask

  // Entered with last = 0.
  task automatic test_flush();
    set_data(1, 32'hAAAA_0001, 5'd17, 1'b1);
    set_data(2, 32'hBBBB_0002, 5'd18, 1'b1);
    req_i = 4'b0110; padv_wb_i = 1'b1; pipeline_flush_i = 1'b1;
    #1;
    n_tests++;
    if (ack_o !== 4'b0000 || wb_pending_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_ack: got ack=%b pending=%b expected 0000 1", ack_o, wb_pending_o);
    end
    tick();
    pipeline_flush_i = 1'b0;
    n_tests++;
    if (wb_valid_o !== 1'b0 || wb_grant_o !== 4'b0000) begin
      n_fail++; $display("FAIL flush_wb: got valid=%b grant=%b expected 0 0000", wb_valid_o, wb_grant_o);
    end
    #1;
    n_tests++;
    if (ack_o !== 4'b0010) begin n_fail++; $display("FAIL post_flush_ack: got %b expected 0010", ack_o); end
    tick();
    req_i = 4'b0100;
    n_tests++;
    if (wb_grant_o !== 4'b0010 || wb_result_o !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL post_flush_wb: got grant=%b result=%h expected 0010 aaaa0001", wb_grant_o, wb_result_o);
    end
  endtask

  task automatic test_stall();
    padv_wb_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (ack_o !== 4'b0000 || wb_pending_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_ack[%0d]: got ack=%b pending=%b expected 0000 1", i, ack_o, wb_pending_o);
      end
      tick();
      n_tests++;
      if (wb_valid_o !== 1'b1 || wb_grant_o !== 4'b0010 || wb_result_o !== 32'hAAAA_0001) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b grant=%b result=%h expected 1 0010 aaaa0001",
                           i, wb_valid_o, wb_grant_o, wb_result_o);
      end
    end
    padv_wb_i = 1'b1;
    #1;
    n_tests++;
    if (ack_o !== 4'b0100) begin n_fail++; $display("FAIL stall_release_ack: got %b expected 0100", ack_o); end
    tick();
    req_i = 4'b0000;
    n_tests++;
    if (wb_grant_o !== 4'b0100 || wb_result_o !== 32'hBBBB_0002 || wb_rfd_adr_o !== 5'd18) begin
      n_fail++; $display("FAIL stall_release_wb: got grant=%b result=%h adr=%0d expected 0100 bbbb0002 18",
                         wb_grant_o, wb_result_o, wb_rfd_adr_o);
    end
  endtask

  task automatic test_no_rf_wb();
    set_data(3, 32'h0000_C0DE, 5'd31, 1'b0);
    req_i = 4'b1000; padv_wb_i = 1'b1;
    #1;
    n_tests++;
    if (ack_o !== 4'b1000) begin n_fail++; $display("FAIL norfwb_ack: got %b expected 1000", ack_o); end
    tick();
    req_i = 4'b0000;
    n_tests++;
    if (wb_valid_o !== 1'b1 || wb_rf_wb_o !== 1'b0 || wb_grant_o !== 4'b1000 || wb_rfd_adr_o !== 5'd31) begin
      n_fail++; $display("FAIL norfwb_wb: got valid=%b rfwb=%b grant=%b adr=%0d expected 1 0 1000 31",
                         wb_valid_o, wb_rf_wb_o, wb_grant_o, wb_rfd_adr_o);
    end
  endtask

  // Last winner is 3 here; a mid-run reset must bring the pointer back so 0 wins first.
  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) set_data(k, 32'h5000_0000 + k, 5'(k), 1'b1);
    req_i = 4'b0011; padv_wb_i = 1'b1;
    tick();
    req_i = 4'b0110; rst = 1'b1;
    #1;
    n_tests++;
    if (ack_o !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack: got %b expected 0000", ack_o); end
    tick();
    n_tests++;
    if ({wb_valid_o, wb_rf_wb_o, wb_grant_o} !== 6'b0 || wb_result_o !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_wb: got valid=%b rfwb=%b grant=%b result=%h expected all 0",
                         wb_valid_o, wb_rf_wb_o, wb_grant_o, wb_result_o);
    end
    rst = 1'b0; req_i = 4'b1111;
    #1;
    n_tests++;
    if (ack_o !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first: got %b expected 0001", ack_o); end
    tick();
    req_i = 4'b0000;
  endtask

`ifdef MOR1KX_WB_ARB_LSU_PRIO_EN
  task automatic test_lsu_prio();
    logic [3:0] exp_ack [5];
    logic [3:0] reqs    [5];
    do_reset();
    reqs[0] = 4'b1011; reqs[1] = 4'b1011; reqs[2] = 4'b1011; reqs[3] = 4'b1010; reqs[4] = 4'b1000;
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0001; exp_ack[2] = 4'b0001;
    exp_ack[3] = 4'b0010; exp_ack[4] = 4'b1000;
    for (int k = 0; k < 4; k++) set_data(k, 32'h7000_0000 + k, 5'(20 + k), 1'b1);
    padv_wb_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_i = reqs[i];
      #1;
      n_tests++;
      if (ack_o !== exp_ack[i]) begin n_fail++; $display("FAIL lsu_prio_ack[%0d]: got %b expected %b", i, ack_o, exp_ack[i]); end
      tick();
    end
    req_i = 4'b0000;
  endtask
`endif

  initial begin
    rst = 1'b1; padv_wb_i = 1'b0; pipeline_flush_i = 1'b0;
    req_i = '0; req_rf_wb_i = '0; req_result_i = '0; req_rfd_adr_i = '0;
    test_reset();
`ifdef MOR1KX_WB_ARB_LSU_PRIO_EN
    test_lsu_prio();
`else
    test_single();
    test_round_robin();
    test_flush();
    test_stall();
    test_no_rf_wb();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1);
  end

endmodule
